// File: rtl/axi_lite_req_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite master command port among NUM_REQ requesters; optional WAIT watchdog via ARB_TIMEOUT_EN.
// Latency: req_ready in T, request pulse in T+1; completion handshake in C, rsp_valid in C+1, next grant in C+2.
// Backpressure: one command in flight; req_ready is withheld from all requesters until the response pulse has retired.
module axi_lite_req_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 7,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                           ACLK,
    input  logic                           ARESET,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_rdata,
    output logic                           rsp_err,
    output logic                           write_request,
    output logic                           read_request,
    output logic [ADDR_WIDTH-1:0]          ext_waddr,
    output logic [ADDR_WIDTH-1:0]          ext_raddr,
    output logic [DATA_WIDTH-1:0]          ext_wdata,
    input  logic                           BVALID,
    input  logic                           BREADY,
    input  logic [1:0]                     BRESP,
    input  logic                           RVALID,
    input  logic                           RREADY,
    input  logic [DATA_WIDTH-1:0]          RDATA,
    output logic                           busy,
    output logic                           timeout
);

    localparam int GW = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("axi_lite_req_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    state_t          state, state_nxt;
    cmd_t            cmd_q, cmd_sel;
    logic [GW-1:0]   grant_q, last_grant, pick;
    logic            grant_fire;
    logic            done;
    logic            expire;

    // Nearest valid requester after last_grant, measured as rotational distance.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [GW-1:0]      lg);
        logic [GW-1:0] sel;
        int            best_d;
        int            d;
        sel    = lg;
        best_d = NUM_REQ;
        for (int i = 0; i < NUM_REQ; i++) begin
            d = i - int'(lg) - 1;
            if (d < 0) d = d + NUM_REQ;
            if (v[i] && d < best_d) begin
                best_d = d;
                sel    = GW'(i);
            end
        end
        return sel;
    endfunction

    always_comb begin
        pick    = rr_pick(req_valid, last_grant);
        cmd_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == GW'(i)) begin
                cmd_sel.write = req_write[i];
                cmd_sel.addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                cmd_sel.wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Only the channel matching the in-flight op can complete it.
    always_comb begin
        done = 1'b0;
        if (state == WAIT) begin
            done = cmd_q.write ? (BVALID && BREADY) : (RVALID && RREADY);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt     = state;
        req_ready     = '0;
        rsp_valid     = '0;
        write_request = 1'b0;
        read_request  = 1'b0;
        grant_fire    = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid && !ARESET) begin
                    req_ready  = NUM_REQ'(1) << pick;
                    grant_fire = 1'b1;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                write_request = cmd_q.write;
                read_request  = !cmd_q.write;
                state_nxt     = WAIT;
            end
            WAIT: begin
                if (done || expire) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = NUM_REQ'(1) << grant_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cmd_q      <= '0;
            grant_q    <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            if (grant_fire) begin
                cmd_q   <= cmd_sel;
                grant_q <= pick;
            end
            if (state == RESP) last_grant <= grant_q;
            if (done) begin
                rsp_err <= cmd_q.write ? (BRESP != 2'b00) : 1'b0;
                if (!cmd_q.write) rsp_rdata <= RDATA;
            end else if (expire) begin
                rsp_err <= 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_nxt;
    logic          timeout_q;

    assign wait_cnt_nxt = wait_cnt + CW'(1);
    // A completion landing in the expiry cycle wins over the watchdog.
    assign expire = (state == WAIT) && !done && (wait_cnt_nxt == CW'(TIMEOUT_CYCLES));

    always_ff @(posedge ACLK) begin
        if (ARESET || state != WAIT) wait_cnt <= '0;
        else                         wait_cnt <= wait_cnt_nxt;
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) timeout_q <= 1'b0;
        else        timeout_q <= expire;
    end

    assign timeout = timeout_q;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign ext_waddr = cmd_q.addr;
    assign ext_raddr = cmd_q.addr;
    assign ext_wdata = cmd_q.wdata;

endmodule

// File: tb/tb_axi_lite_req_arbiter.sv
// Directed bench for axi_lite_req_arbiter: write/read, contention, error, stray handshakes, reset, watchdog.
// The bench plays both requesters and the AXI slave; a small array stands in for slave memory.
module tb_axi_lite_req_arbiter;
    localparam int DW = 32;
    localparam int AW = 7;
    localparam int NR = 2;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_write = '0;
    logic [NR*AW-1:0]  req_addr = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              write_request;
    logic              read_request;
    logic [AW-1:0]     ext_waddr;
    logic [AW-1:0]     ext_raddr;
    logic [DW-1:0]     ext_wdata;
    logic              BVALID = 1'b0;
    logic              BREADY = 1'b0;
    logic [1:0]        BRESP = 2'b00;
    logic              RVALID = 1'b0;
    logic              RREADY = 1'b0;
    logic [DW-1:0]     RDATA = '0;
    logic              busy;
    logic              timeout;

    int n_tests = 0;
    int n_fail  = 0;
    logic [DW-1:0] mem [128];

    axi_lite_req_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .TIMEOUT_CYCLES(16)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .write_request(write_request), .read_request(read_request),
        .ext_waddr(ext_waddr), .ext_raddr(ext_raddr), .ext_wdata(ext_wdata),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA),
        .busy(busy), .timeout(timeout)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge ACLK) begin
        n_tests++;
        assert ($countones(req_ready) <= 1 && $countones(rsp_valid) <= 1) else begin
            n_fail++;
            $error("FAIL onehot: observed req_ready=%b rsp_valid=%b expected at most one bit each",
                   req_ready, rsp_valid);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no end of test expected finish before 100000");
        $fatal(1, "bench watchdog expired");
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic w,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[r]            = v;
        req_write[r]            = w;
        req_addr[r*AW +: AW]    = a;
        req_wdata[r*DW +: DW]   = d;
    endtask

    task automatic clr_axi();
        BVALID = 1'b0; BREADY = 1'b0; BRESP = 2'b00;
        RVALID = 1'b0; RREADY = 1'b0; RDATA = '0;
    endtask

    // Entered in an IDLE cycle with requests already driven; returns settled in the IDLE cycle two after the response.
    task automatic run_cmd(input string name, input int r, input logic wr,
                           input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] bresp,
                           input logic exp_err, input logic [DW-1:0] exp_rdata,
                           input logic drop, input logic stray);
        #1;
        chk({name, ".ready"}, 32'(req_ready), 32'(1) << r);
        chk({name, ".busy_idle"}, 32'(busy), 32'd0);
        tick();
        if (drop) req_valid[r] = 1'b0;
        #1;
        chk({name, ".wreq"}, 32'(write_request), 32'(wr));
        chk({name, ".rreq"}, 32'(read_request), 32'(!wr));
        chk({name, ".addr"}, wr ? 32'(ext_waddr) : 32'(ext_raddr), 32'(a));
        if (wr) chk({name, ".wdata"}, ext_wdata, d);
        chk({name, ".ready_issue"}, 32'(req_ready), 32'd0);
        if (write_request) mem[ext_waddr] = ext_wdata;
        tick();
        for (int i = 0; i < 2; i++) begin
            if (stray) begin
                if (wr) begin RVALID = 1'b1; RREADY = 1'b1; RDATA = 32'h12345678; end
                else    begin BVALID = 1'b1; BREADY = 1'b1; BRESP = 2'b10; end
            end
            #1;
            chk({name, ".wait_rsp"}, 32'(rsp_valid), 32'd0);
            chk({name, ".wait_pulse"}, 32'({write_request, read_request}), 32'd0);
            tick();
            clr_axi();
        end
        if (wr) begin BVALID = 1'b1; BREADY = 1'b1; BRESP = bresp; end
        else    begin RVALID = 1'b1; RREADY = 1'b1; RDATA = mem[ext_raddr]; end
        tick();
        clr_axi();
        #1;
        chk({name, ".rsp_valid"}, 32'(rsp_valid), 32'(1) << r);
        chk({name, ".rsp_err"}, 32'(rsp_err), 32'(exp_err));
        chk({name, ".rsp_rdata"}, rsp_rdata, exp_rdata);
        chk({name, ".timeout"}, 32'(timeout), 32'd0);
        chk({name, ".addr_held"}, wr ? 32'(ext_waddr) : 32'(ext_raddr), 32'(a));
        tick();
        #1;
        chk({name, ".rsp_done"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'hA5000000 | 32'(i);
        tick();
        tick();
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst.pulses", 32'({write_request, read_request}), 32'd0);
        chk("rst.ext", 32'({ext_waddr, ext_raddr}) | ext_wdata, 32'd0);
        chk("rst.rsp_rdata", rsp_rdata, 32'd0);
        chk("rst.rsp_err", 32'(rsp_err), 32'd0);
        chk("rst.timeout", 32'(timeout), 32'd0);
        ARESET = 1'b0;

        set_req(0, 1'b1, 1'b1, 7'h10, 32'hDEADBEEF);
        run_cmd("wr0", 0, 1'b1, 7'h10, 32'hDEADBEEF, 2'b00, 1'b0, 32'h0, 1'b1, 1'b0);
        set_req(0, 1'b1, 1'b0, 7'h10, 32'h0);
        run_cmd("rd0", 0, 1'b0, 7'h10, 32'h0, 2'b00, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0);

        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        set_req(0, 1'b1, 1'b1, 7'h20, 32'h11111111);
        set_req(1, 1'b1, 1'b0, 7'h21, 32'h0);
        run_cmd("rr_a", 0, 1'b1, 7'h20, 32'h11111111, 2'b00, 1'b0, 32'h0, 1'b0, 1'b0);
        run_cmd("rr_b", 1, 1'b0, 7'h21, 32'h0, 2'b00, 1'b0, 32'hA5000021, 1'b0, 1'b0);
        run_cmd("rr_c", 0, 1'b1, 7'h20, 32'h11111111, 2'b00, 1'b0, 32'hA5000021, 1'b0, 1'b0);
        run_cmd("rr_d", 1, 1'b0, 7'h21, 32'h0, 2'b00, 1'b0, 32'hA5000021, 1'b1, 1'b0);
        req_valid = '0;

        set_req(1, 1'b1, 1'b1, 7'h30, 32'h0BADF00D);
        run_cmd("werr", 1, 1'b1, 7'h30, 32'h0BADF00D, 2'b10, 1'b1, 32'hA5000021, 1'b1, 1'b0);

        BVALID = 1'b1; BREADY = 1'b1; RVALID = 1'b1; RREADY = 1'b1; RDATA = 32'h77777777;
        tick();
        clr_axi();
        #1;
        chk("idle_stray.busy", 32'(busy), 32'd0);
        chk("idle_stray.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("idle_stray.rdata", rsp_rdata, 32'hA5000021);

        set_req(0, 1'b1, 1'b1, 7'h31, 32'hCAFEF00D);
        run_cmd("stray_w", 0, 1'b1, 7'h31, 32'hCAFEF00D, 2'b00, 1'b0, 32'hA5000021, 1'b1, 1'b1);
        set_req(1, 1'b1, 1'b0, 7'h31, 32'h0);
        run_cmd("stray_r", 1, 1'b0, 7'h31, 32'h0, 2'b00, 1'b0, 32'hCAFEF00D, 1'b1, 1'b1);

        set_req(0, 1'b1, 1'b0, 7'h05, 32'h0);
        #1;
        chk("midrst.ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        tick();
        #1;
        chk("midrst.busy_wait", 32'(busy), 32'd1);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst.rdata", rsp_rdata, 32'd0);
        chk("midrst.ext", 32'(ext_raddr), 32'd0);
        chk("midrst.pulses", 32'({write_request, read_request, timeout, rsp_err}), 32'd0);
        for (int i = 0; i < 3; i++) begin
            RVALID = 1'b1; RREADY = 1'b1; RDATA = 32'h99999999;
            tick();
            #1;
            chk("midrst.no_rsp", 32'(rsp_valid), 32'd0);
        end
        clr_axi();

        set_req(0, 1'b1, 1'b0, 7'h05, 32'h0);
        set_req(1, 1'b1, 1'b1, 7'h06, 32'h600DF00D);
        run_cmd("post_a", 0, 1'b0, 7'h05, 32'h0, 2'b00, 1'b0, 32'hA5000005, 1'b1, 1'b0);
        run_cmd("post_b", 1, 1'b1, 7'h06, 32'h600DF00D, 2'b00, 1'b0, 32'hA5000005, 1'b1, 1'b0);
        chk("post.mem", mem[6], 32'h600DF00D);

        set_req(0, 1'b1, 1'b1, 7'h40, 32'h44444444);
        #1;
        chk("wd.ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = '0;
        tick();
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("wd.wait_rsp", 32'(rsp_valid), 32'd0);
            chk("wd.wait_timeout", 32'(timeout), 32'd0);
            tick();
        end
        #1;
        chk("wd.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wd.timeout", 32'(timeout), 32'd1);
        chk("wd.rsp_err", 32'(rsp_err), 32'd1);
        chk("wd.rdata", rsp_rdata, 32'hA5000005);
        tick();
        #1;
        chk("wd.timeout_end", 32'(timeout), 32'd0);
        chk("wd.busy_end", 32'(busy), 32'd0);
`else
        for (int i = 0; i < 40; i++) begin
            #1;
            chk("wd.busy_hold", 32'(busy), 32'd1);
            chk("wd.no_rsp", 32'(rsp_valid), 32'd0);
            chk("wd.timeout", 32'(timeout), 32'd0);
            tick();
        end
        BVALID = 1'b1; BREADY = 1'b1; BRESP = 2'b00;
        tick();
        clr_axi();
        #1;
        chk("wd.rsp_valid", 32'(rsp_valid), 32'd1);
        chk("wd.rsp_err", 32'(rsp_err), 32'd0);
        tick();
        #1;
        chk("wd.busy_end", 32'(busy), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_lite_req_arbiter.md
# axi_lite_req_arbiter

Round-robin arbiter that shares the single AXI4-Lite master's external command port between NUM_REQ independent requesters. Each requester posts one read or write command. The arbiter grants one command at a time and drives the master's write_request/read_request and address/data inputs. It watches the AXI write-response and read-data handshakes to detect completion, then returns the result to the granted requester. The arbiter sits between requester logic and the master's external control port; the AXI channels themselves pass untouched between master and slave.

## Interface
- DATA_WIDTH, 32, data width; matches master/slave.
- ADDR_WIDTH, 7, address width; matches master/slave.
- NUM_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 256, watchdog limit in WAIT; used only with ARB_TIMEOUT_EN.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - ACLK  in  1  clock; all logic on rising edge.
  - ARESET  in  1  synchronous, active-high reset.
- Requester side (requester i uses bit i / slice i):
  - req_valid  in  NUM_REQ  command pending.
  - req_write  in  NUM_REQ  1 = write, 0 = read.
  - req_addr  in  NUM_REQ*ADDR_WIDTH  command address.
  - req_wdata  in  NUM_REQ*DATA_WIDTH  write data.
  - req_ready  out  NUM_REQ  one-hot; command accepted this cycle.
  - rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse.
  - rsp_rdata  out  DATA_WIDTH  read data; valid with rsp_valid.
  - rsp_err  out  1  error; valid with rsp_valid.
- Master command port:
  - write_request  out  1  one-cycle write start pulse.
  - read_request  out  1  one-cycle read start pulse.
  - ext_waddr  out  ADDR_WIDTH  write address.
  - ext_raddr  out  ADDR_WIDTH  read address.
  - ext_wdata  out  DATA_WIDTH  write data.
- AXI completion monitor:
  - BVALID, BREADY  in  1 each  write-response handshake.
  - BRESP  in  2  write response code.
  - RVALID, RREADY  in  1 each  read-data handshake.
  - RDATA  in  DATA_WIDTH  read data.
- Status:
  - busy  out  1  high when the FSM is not in IDLE.
  - timeout  out  1  one-cycle pulse on watchdog expiry.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Round-robin search starts at index last_grant+1 (mod NUM_REQ); the first asserted req_valid wins as g.
  - req_ready[g] is asserted combinationally in the same cycle.
  - On that clock edge the arbiter latches g, op, addr and wdata, then moves to ISSUE.
- ISSUE:
  - Pulses write_request or read_request for exactly one cycle.
  - ext_waddr/ext_raddr/ext_wdata are driven from the latched command and held stable from ISSUE through RESP.
  - Moves to WAIT.
- WAIT:
  - Write: on BVALID&BREADY, capture rsp_err = (BRESP != 2'b00).
  - Read: on RVALID&RREADY, capture rsp_rdata = RDATA and rsp_err = 0.
  - Then moves to RESP. The handshake of the non-matching channel is ignored.
- RESP: pulses rsp_valid[g], sets last_grant = g, returns to IDLE.
- Requesters must hold req_valid and their fields stable until req_ready. A requester may hold req_valid high again immediately after rsp_valid.

## Timing
- Reset values:
  - State IDLE; last_grant = NUM_REQ-1, so requester 0 has first priority.
  - All outputs 0, including rsp_rdata, rsp_err, busy and timeout.
- Latency:
  - req_ready in cycle T, then request pulse in T+1.
  - Completion handshake in cycle C, then rsp_valid in C+1.
  - Next grant possible in C+2.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ-1,0.
- Boundary conditions:
  - Simultaneous req_valid: only one req_ready per cycle.
  - B/R handshakes outside WAIT are ignored.
  - rsp_rdata holds its last value between responses; it is updated only on read completion.
  - ARESET mid-transaction: returns to IDLE next edge, no rsp_valid issued, the latched command is discarded. The master must be reset together with the arbiter.

## Configuration
- ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) runs in WAIT.
  - When it reaches TIMEOUT_CYCLES without completion: timeout pulses, rsp_err = 1, rsp_rdata is unchanged, FSM goes to RESP.
  - A completion in the expiry cycle takes precedence; no timeout is flagged.
- ARB_TIMEOUT_EN undefined:
  - No counter is built; WAIT persists until completion.
  - timeout is tied to 0.

## Test plan
- Single write: req0 write addr 0x10 data 0xDEADBEEF → req_ready[0] in T, write_request pulse in T+1, after BVALID&BREADY rsp_valid[0] with rsp_err=0; a follow-up read of 0x10 returns rsp_rdata=0xDEADBEEF.
- Contention: req0 and req1 valid together from reset → grant order 0,1,0,1 over four commands; never two req_ready bits set in one cycle.
- Write error: force BRESP=2'b10 → rsp_err=1 on rsp_valid[g].
- Stray handshake: drive RVALID&RREADY while a write waits → ignored; completion only on BVALID&BREADY.
- Reset mid-WAIT: assert ARESET for one cycle → busy=0, no rsp_valid, all outputs 0 next cycle.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): hold BVALID low → timeout pulse and rsp_err=1 exactly 16 cycles after entering WAIT.
